// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler.
// Holds the scheduler state encoding and the burst-length clamp.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    SERVE = 2'd2
  } sched_state_e;

  // A zero burst still moves one word so a grant can never stall the ring.
  function automatic int unsigned burst_clamp(input int unsigned burst,
                                              input int unsigned burst_max);
    int unsigned res;
    if (burst == 32'd0) begin
      res = 32'd1;
    end else if (burst > burst_max) begin
      res = burst_max;
    end else begin
      res = burst;
    end
    return res;
  endfunction

endpackage

// File: rtl/dffr.sv
// Shared register cell: D flop with asynchronous active-low clear to zero.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // State capture with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_o <= '0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fifo_rr_sched_arb.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_FIFO     = 4,
  parameter int LOG_NUM_FIFO = $clog2(NUM_FIFO)
) (
  input  logic [NUM_FIFO-1:0]     req_i,
  input  logic [LOG_NUM_FIFO-1:0] ptr_i,
  output logic [LOG_NUM_FIFO-1:0] gnt_idx_o,
  output logic                    gnt_vld_o
);

  localparam int SW = LOG_NUM_FIFO + 1;

  logic [SW-1:0]           raw_s;
  logic [LOG_NUM_FIFO-1:0] idx_s;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    raw_s     = '0;
    idx_s     = '0;
    for (int i = NUM_FIFO - 1; i >= 0; i--) begin
      raw_s     = {1'b0, ptr_i} + SW'(i);
      idx_s     = (raw_s >= SW'(NUM_FIFO)) ? LOG_NUM_FIFO'(raw_s - SW'(NUM_FIFO))
                                           : raw_s[LOG_NUM_FIFO-1:0];
      gnt_vld_o = gnt_vld_o | req_i[idx_s];
      gnt_idx_o = req_i[idx_s] ? idx_s : gnt_idx_o;
    end
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin drain scheduler: pops granted FIFO in bursts onto one
// registered valid/ready output channel tagged with the source index.
module fifo_rr_sched #(
  parameter int NUM_FIFO     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_MAX    = 4,
  parameter int LOG_NUM_FIFO = $clog2(NUM_FIFO),
  parameter int BURST_WIDTH  = $clog2(BURST_MAX + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               flush_i,
  input  logic                               en_i,
  input  logic [BURST_WIDTH-1:0]             burst_i,
  input  logic [NUM_FIFO-1:0]                fifo_empty_i,
  input  logic [NUM_FIFO-1:0][DATA_WIDTH-1:0] fifo_dat_i,
  output logic [NUM_FIFO-1:0]                fifo_pop_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [DATA_WIDTH-1:0]              dat_o,
  output logic [LOG_NUM_FIFO-1:0]            id_o,
  output logic                               busy_o
);

  import fifo_sched_pkg::*;

  sched_state_e            state_q, state_d;
  logic [1:0]              state_raw_q;
  logic [LOG_NUM_FIFO-1:0] ptr_q, ptr_d;
  logic [LOG_NUM_FIFO-1:0] grant_q, grant_d;
  logic [LOG_NUM_FIFO-1:0] id_q, id_d;
  logic [BURST_WIDTH-1:0]  limit_q, limit_d;
  logic [BURST_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;

  logic [LOG_NUM_FIFO-1:0] arb_idx_s;
  logic                    arb_vld_s;
  logic                    pop_s;
  logic                    burst_end_s;
  logic [BURST_WIDTH-1:0]  cnt_inc_s;
  logic [LOG_NUM_FIFO-1:0] grant_inc_s;

  assign state_q = sched_state_e'(state_raw_q);

  rr_arbiter #(
    .NUM_FIFO     (NUM_FIFO),
    .LOG_NUM_FIFO (LOG_NUM_FIFO)
  ) u_arb (
    .req_i     (~fifo_empty_i),
    .ptr_i     (ptr_q),
    .gnt_idx_o (arb_idx_s),
    .gnt_vld_o (arb_vld_s)
  );

  // A pop needs a word at the head and room in the output register this cycle.
  assign pop_s = (state_q == SERVE) & ~flush_i & en_i & ~fifo_empty_i[grant_q]
               & (~valid_q | ready_i);

  assign cnt_inc_s   = cnt_q + BURST_WIDTH'(1);
  assign grant_inc_s = (grant_q == LOG_NUM_FIFO'(NUM_FIFO - 1)) ? '0
                                                                : grant_q + LOG_NUM_FIFO'(1);
  assign burst_end_s = (pop_s & (cnt_inc_s == limit_q)) | fifo_empty_i[grant_q] | ~en_i;

  assign fifo_pop_o = pop_s ? (NUM_FIFO'(1) << grant_q) : '0;

  // Next-state and output-register logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    limit_d = limit_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    dat_d   = dat_q;
    id_d    = id_q;
    if (flush_i) begin
      state_d = IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (pop_s) begin
        valid_d = 1'b1;
        dat_d   = fifo_dat_i[grant_q];
        id_d    = grant_q;
        cnt_d   = cnt_inc_s;
      end else if (ready_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
      case (state_q)
        IDLE: begin
          if (en_i) begin
            state_d = ARB;
          end else begin
            state_d = IDLE;
          end
        end
        ARB: begin
          if (!en_i) begin
            state_d = IDLE;
          end else if (arb_vld_s) begin
            state_d = SERVE;
            grant_d = arb_idx_s;
            limit_d = BURST_WIDTH'(burst_clamp(32'(burst_i), BURST_MAX));
            cnt_d   = '0;
          end else begin
            state_d = ARB;
          end
        end
        SERVE: begin
          if (burst_end_s) begin
            state_d = ARB;
            ptr_d   = grant_inc_s;
          end else begin
            state_d = SERVE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE) | valid_d;
  end

  dffr #(.W(2))            u_state (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(state_d), .q_o(state_raw_q));
  dffr #(.W(LOG_NUM_FIFO)) u_ptr   (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(ptr_d),   .q_o(ptr_q));
  dffr #(.W(LOG_NUM_FIFO)) u_grant (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(grant_d), .q_o(grant_q));
  dffr #(.W(BURST_WIDTH))  u_limit (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(limit_d), .q_o(limit_q));
  dffr #(.W(BURST_WIDTH))  u_cnt   (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(cnt_d),   .q_o(cnt_q));
  dffr #(.W(1))            u_valid (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(valid_d), .q_o(valid_q));
  dffr #(.W(1))            u_busy  (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(busy_d),  .q_o(busy_q));
  dffr #(.W(DATA_WIDTH))   u_dat   (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(dat_d),   .q_o(dat_q));
  dffr #(.W(LOG_NUM_FIFO)) u_id    (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(id_d),    .q_o(id_q));

  assign valid_o = valid_q;
  assign dat_o   = dat_q;
  assign id_o    = id_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched: queue-based FIFO bank plus a behavioural scheduler
// model compared against the DUT every cycle, with directed and random phases.
module tb_fifo_rr_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BM = 4;
  localparam int LW = 2;
  localparam int BW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b1;
  logic              flush, en, ready;
  logic [BW-1:0]     burst;
  logic [N-1:0]      empty;
  logic [N-1:0][DW-1:0] fdat;
  logic [N-1:0]      pop;
  logic              valid;
  logic [DW-1:0]     dat;
  logic [LW-1:0]     id;
  logic              busy;

  fifo_rr_sched #(.NUM_FIFO(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .en_i(en), .burst_i(burst),
    .fifo_empty_i(empty), .fifo_dat_i(fdat), .fifo_pop_o(pop), .valid_o(valid),
    .ready_i(ready), .dat_o(dat), .id_o(id), .busy_o(busy)
  );

  logic [DW-1:0] fq [N][$];

  // model: ph 0 = idle, 1 = arbitrating, 2 = serving a burst
  int ph, ptr, grant, limit, cnt, mid;
  bit mv;
  logic [DW-1:0] mdat;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int log_id[$];
  int log_cyc[$];
  logic [DW-1:0] log_dat[$];
  logic [N-1:0] last_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ph = 0; ptr = 0; grant = 0; limit = 1; cnt = 0; mv = 1'b0; mdat = '0; mid = 0;
  endtask

  function automatic bit m_pop();
    return (ph == 2) && !flush && en && (fq[grant].size() > 0) && (!mv || ready);
  endfunction

  task automatic model_step(input bit p);
    bit emp;
    bit found;
    int b;
    int f;
    if (flush) begin
      ph = 0; ptr = 0; cnt = 0; mv = 1'b0;
      return;
    end
    emp = (fq[grant].size() == 0);
    if (mv && ready) mv = 1'b0;
    case (ph)
      0: if (en) ph = 1;
      1: begin
        if (!en) ph = 0;
        else begin
          found = 1'b0;
          b = int'(burst);
          for (int k = 0; k < N; k++) begin
            f = (ptr + k) % N;
            if (!found && fq[f].size() > 0) begin
              found = 1'b1;
              grant = f;
              limit = (b == 0) ? 1 : ((b > BM) ? BM : b);
              cnt = 0;
              ph = 2;
            end
          end
        end
      end
      2: begin
        if (p) begin
          mdat = fq[grant].pop_front();
          mid = grant;
          mv = 1'b1;
          cnt++;
        end
        if ((p && cnt == limit) || emp || !en) begin
          ph = 1;
          ptr = (grant + 1) % N;
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < N; i++) begin
      empty[i] = (fq[i].size() == 0);
      fdat[i]  = (fq[i].size() == 0) ? 32'hDEAD_0000 : fq[i][0];
    end
  endtask

  task automatic check_regs();
    chk("valid", valid, mv);
    chk("busy", busy, (ph != 0) || mv);
    chk("dat", dat, mdat);
    chk("id", id, mid);
  endtask

  task automatic cycle(input bit f, input bit e, input bit r, input int b);
    bit mp;
    @(negedge clk);
    check_regs();
    flush = f; en = e; ready = r; burst = BW'(b);
    drive_fifos();
    #1;
    mp = m_pop();
    chk("pop", pop, mp ? (64'd1 << grant) : 64'd0);
    last_pop = pop;
    if (valid && ready) begin
      log_id.push_back(int'(id));
      log_dat.push_back(dat);
      log_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    model_step(mp);
  endtask

  task automatic run(input int n, input bit e, input bit r, input int b);
    for (int i = 0; i < n; i++) cycle(1'b0, e, r, b);
  endtask

  task automatic clear_log();
    log_id.delete(); log_dat.delete(); log_cyc.delete();
  endtask

  task automatic chk_ids(input string name, input int exp[$]);
    chk({name, "_count"}, log_id.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < log_id.size()) chk(name, log_id[i], exp[i]);
    end
  endtask

  task automatic fill(input int f, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) fq[f].push_back(base + DW'(k));
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_valid"}, valid, 0);
    chk({name, "_dat"}, dat, 0);
    chk({name, "_id"}, id, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_pop"}, pop, 0);
  endtask

  int exp_ids[$];
  int total;
  int wsel;

  initial begin
    flush = 1'b0; en = 1'b0; ready = 1'b0; burst = '0;
    model_reset();
    drive_fifos();
    #1 rst_n = 1'b0;
    #2 chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(2, 1'b0, 1'b1, 4);

    // single queue: three words from FIFO 2 back to back, then ptr lands on 3
    clear_log();
    fill(2, 3, 32'h0000_00A1);
    run(12, 1'b1, 1'b1, 4);
    exp_ids = '{2, 2, 2};
    chk_ids("single_id", exp_ids);
    if (log_dat.size() == 3) begin
      chk("single_dat0", log_dat[0], 32'h0000_00A1);
      chk("single_dat1", log_dat[1], 32'h0000_00A2);
      chk("single_dat2", log_dat[2], 32'h0000_00A3);
      chk("single_back2back", log_cyc[2] - log_cyc[0], 2);
    end
    fill(0, 1, 32'h0000_0C00);
    fill(3, 1, 32'h0000_0C03);
    run(10, 1'b1, 1'b1, 4);
    exp_ids = '{2, 2, 2, 3, 0};
    chk_ids("ptr_after_single", exp_ids);

    // round-robin fairness with burst 2
    cycle(1'b1, 1'b1, 1'b1, 2);
    clear_log();
    for (int i = 0; i < N; i++) fill(i, 3, DW'(32'h100 * (i + 1)));
    run(40, 1'b1, 1'b1, 2);
    exp_ids = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
    chk_ids("rr", exp_ids);

    // clamp: burst 0 acts as 1, burst 7 acts as BURST_MAX
    cycle(1'b1, 1'b1, 1'b1, 0);
    clear_log();
    fill(0, 2, 32'h0000_0D00);
    fill(1, 2, 32'h0000_0D10);
    run(20, 1'b1, 1'b1, 0);
    exp_ids = '{0, 1, 0, 1};
    chk_ids("clamp0", exp_ids);
    cycle(1'b1, 1'b1, 1'b1, 7);
    clear_log();
    fill(0, 5, 32'h0000_0E00);
    fill(1, 5, 32'h0000_0E10);
    run(30, 1'b1, 1'b1, 7);
    exp_ids = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1};
    chk_ids("clamp7", exp_ids);

    // backpressure mid-burst: no pops and a frozen output word
    cycle(1'b1, 1'b1, 1'b1, 4);
    clear_log();
    fill(1, 4, 32'h0000_B100);
    run(3, 1'b1, 1'b1, 4);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 4);
      chk("bp_pop", last_pop, 0);
      chk("bp_dat", dat, 32'h0000_B100);
    end
    run(10, 1'b1, 1'b1, 4);
    exp_ids = '{1, 1, 1, 1};
    chk_ids("bp_id", exp_ids);
    if (log_dat.size() == 4) chk("bp_last", log_dat[3], 32'h0000_B103);

    // flush while FIFO 3 is mid-burst
    cycle(1'b1, 1'b1, 1'b1, 4);
    fill(3, 4, 32'h0000_F300);
    run(4, 1'b1, 1'b1, 4);
    fill(1, 2, 32'h0000_F100);
    cycle(1'b1, 1'b1, 1'b1, 4);
    #2;
    chk("flush_valid", valid, 0);
    chk("flush_busy", busy, 0);
    clear_log();
    run(20, 1'b1, 1'b1, 4);
    exp_ids = '{1, 1, 3, 3};
    chk_ids("after_flush", exp_ids);

    // asynchronous reset between edges in the middle of a burst
    cycle(1'b1, 1'b1, 1'b1, 4);
    fill(0, 6, 32'h0000_5500);
    run(4, 1'b1, 1'b1, 4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    run(20, 1'b1, 1'b1, 4);
    total = 0;
    for (int i = 0; i < N; i++) total += fq[i].size();
    chk("rst_drain", total, 0);
    chk("rst_restart_first", (log_id.size() > 0) ? log_id[0] : -1, 0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom % 3 == 0) begin
        wsel = $urandom % N;
        if (fq[wsel].size() < 8) fq[wsel].push_back($urandom);
      end
      cycle(($urandom % 50) == 0, ($urandom % 10) != 0, ($urandom % 10) < 7,
            int'($urandom % 8));
    end
    run(80, 1'b1, 1'b1, 4);
    total = 0;
    for (int i = 0; i < N; i++) total += fq[i].size();
    chk("final_drain", total, 0);
    chk("final_valid", valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
